// File: rtl/instr_enc_pkg.sv
// rtl/instr_enc_pkg.sv - mnemonics, opcode/funct constants and state enum for the instruction encoder
package instr_enc_pkg;

    typedef enum logic [3:0] {
        MN_ADD    = 4'd0,
        MN_AND    = 4'd1,
        MN_OR     = 4'd2,
        MN_SLT    = 4'd3,
        MN_BRV    = 4'd4,
        MN_JMXOR  = 4'd5,
        MN_LW     = 4'd6,
        MN_SW     = 4'd7,
        MN_BEQ    = 4'd8,
        MN_BLEZAL = 4'd9,
        MN_BALV   = 4'd10,
        MN_NANDI  = 4'd11,
        MN_JALPC  = 4'd12
    } mnem_e;

    // Opcodes shared with the main control decoder
    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_BLEZAL = 6'd36;
    localparam logic [5:0] OP_BALV   = 6'd32;
    localparam logic [5:0] OP_NANDI  = 6'd16;
    localparam logic [5:0] OP_JALPC  = 6'd31;

    // R-format function codes
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_BRV   = 6'd20;
    localparam logic [5:0] FN_JMXOR = 6'd34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_OVF  = 2'd3
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// rtl/instr_encoder_loader_pack.sv - combinational mnemonic+fields to 32-bit word packer
module instr_word_pack
    import instr_enc_pkg::*;
(
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    // Select the format and constant for the mnemonic; codes 13-15 are illegal
    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (mnem_e'(mnem))
            MN_ADD:    word = r_word(rs, rt, rd, FN_ADD);
            MN_AND:    word = r_word(rs, rt, rd, FN_AND);
            MN_OR:     word = r_word(rs, rt, rd, FN_OR);
            MN_SLT:    word = r_word(rs, rt, rd, FN_SLT);
            MN_BRV:    word = r_word(rs, rt, rd, FN_BRV);
            MN_JMXOR:  word = r_word(rs, rt, rd, FN_JMXOR);
            MN_LW:     word = i_word(OP_LW, rs, rt, imm[15:0]);
            MN_SW:     word = i_word(OP_SW, rs, rt, imm[15:0]);
            MN_BEQ:    word = i_word(OP_BEQ, rs, rt, imm[15:0]);
            MN_BLEZAL: word = i_word(OP_BLEZAL, rs, rt, imm[15:0]);
            MN_BALV:   word = i_word(OP_BALV, rs, rt, imm[15:0]);
            MN_NANDI:  word = i_word(OP_NANDI, rs, rt, imm[15:0]);
            MN_JALPC:  word = {OP_JALPC, imm};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - streaming instruction encoder writing words into instruction memory
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_mnem,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              err_illegal,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] MAX_C = (ADDR_W+1)'(MAX_WORDS);

    state_e            state;
    state_e            state_n;
    logic [ADDR_W-1:0] base_q;
    logic              we_q;
    logic [31:0]       word;
    logic              legal;
    logic              xfer;
    logic              start_ok;
    logic [ADDR_W:0]   wc_inc;

    instr_word_pack u_pack (
        .mnem  (in_mnem),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .imm   (in_imm),
        .word  (word),
        .legal (legal)
    );

    // word_count already includes the word in the output register, so no separate pending term is needed
    assign in_ready = (state == ST_LOAD) && (word_count < MAX_C);
    assign xfer     = in_valid && in_ready;
    assign start_ok = start && (state != ST_LOAD);
    assign wc_inc   = word_count + (ADDR_W+1)'(1);

    // A write still in the output stage is dropped when reset is raised over it
    assign imem_we  = we_q && !reset;
    assign busy     = (state == ST_LOAD) || imem_we;
    assign done     = (state == ST_DONE);
    assign overflow = (state == ST_OVF);

    // Session state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: close on in_last, or on the word that fills the session without it
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE, ST_DONE, ST_OVF: begin
                if (start) begin
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (in_last) begin
                        state_n = ST_DONE;
                    end else if (legal && (wc_inc == MAX_C)) begin
                        state_n = ST_OVF;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Output stage, write counter, base latch and sticky illegal flag
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q        <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= 32'd0;
            word_count  <= '0;
            base_q      <= '0;
            err_illegal <= 1'b0;
        end else begin
            we_q <= xfer && legal;
            if (xfer && legal) begin
                imem_wdata <= word;
                imem_addr  <= base_q + word_count[ADDR_W-1:0];
                word_count <= wc_inc;
            end
            if (xfer && !legal) begin
                err_illegal <= 1'b1;
            end
            if (start_ok) begin
                base_q      <= base_addr;
                word_count  <= '0;
                err_illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_mnem;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [25:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, overflow, err_illegal;
    logic [ADDR_W:0]   word_count;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_mnem(in_mnem),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .overflow(overflow), .err_illegal(err_illegal),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; int c; } wr_t;
    wr_t got[$];
    wr_t exp_q[$];

    typedef struct {
        logic [3:0]  m;
        logic [4:0]  rs, rt, rd;
        logic [25:0] imm;
        logic [31:0] word;
        bit          legal;
    } vec_t;
    vec_t tbl[$];

    int funct_of [6] = '{32, 36, 37, 42, 20, 34};
    int op_of    [6] = '{35, 43, 4, 36, 32, 16};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (imem_we) got.push_back('{imem_addr, imem_wdata, cyc});

    function automatic logic [31:0] ref_enc(int m, longint rs, longint rt, longint rd, longint imm);
        longint w;
        if (m < 6)       w = rs * (64'd1 << 21) + rt * (64'd1 << 16) + rd * (64'd1 << 11) + funct_of[m];
        else if (m < 12) w = op_of[m-6] * (64'd1 << 26) + rs * (64'd1 << 21) + rt * (64'd1 << 16) + (imm % 65536);
        else             w = 31 * (64'd1 << 26) + (imm % (64'd1 << 26));
        return w[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start = 1'b1;
        base_addr = b;
        tick();
        start = 1'b0;
        got.delete();
    endtask

    task automatic send(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm, input logic last);
        int waited = 0;
        in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for mnem %0d", m);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    int          base, len, n_acc, written;
    bit          m_done, m_ovf, m_err, closed;
    logic [3:0]  rm  [6];
    logic [4:0]  rrs [6], rrt [6], rrd [6];
    logic [25:0] rim [6];

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_flags", {busy, done, overflow, err_illegal, in_ready}, 0);
        check("rst_wc", word_count, 0);

        // Encoding table: one-word sessions
        tbl.push_back('{4'd0,  5'd1,  5'd2, 5'd3,  26'h0,       32'h00221820, 1'b1});
        tbl.push_back('{4'd1,  5'd3,  5'd4, 5'd5,  26'h0,       32'h00642824, 1'b1});
        tbl.push_back('{4'd2,  5'd7,  5'd8, 5'd9,  26'h0,       32'h00E84825, 1'b1});
        tbl.push_back('{4'd3,  5'd10, 5'd11, 5'd12, 26'h0,      32'h014B602A, 1'b1});
        tbl.push_back('{4'd4,  5'd5,  5'd0, 5'd0,  26'h0,       32'h00A00014, 1'b1});
        tbl.push_back('{4'd5,  5'd31, 5'd0, 5'd31, 26'h0,       32'h03E0F822, 1'b1});
        tbl.push_back('{4'd6,  5'd29, 5'd8, 5'd0,  26'h4,       32'h8FA80004, 1'b1});
        tbl.push_back('{4'd6,  5'd29, 5'd8, 5'd31, 26'h3FF0004, 32'h8FA80004, 1'b1});
        tbl.push_back('{4'd7,  5'd29, 5'd9, 5'd0,  26'h8,       32'hAFA90008, 1'b1});
        tbl.push_back('{4'd8,  5'd1,  5'd2, 5'd0,  26'hFFFE,    32'h1022FFFE, 1'b1});
        tbl.push_back('{4'd9,  5'd3,  5'd0, 5'd0,  26'h10,      32'h90600010, 1'b1});
        tbl.push_back('{4'd10, 5'd2,  5'd0, 5'd0,  26'h20,      32'h80400020, 1'b1});
        tbl.push_back('{4'd11, 5'd4,  5'd6, 5'd0,  26'hFFFF,    32'h4086FFFF, 1'b1});
        tbl.push_back('{4'd12, 5'd0,  5'd0, 5'd0,  26'h40,      32'h7C000040, 1'b1});
        tbl.push_back('{4'd13, 5'd1,  5'd2, 5'd3,  26'h0,       32'h0,        1'b0});
        tbl.push_back('{4'd15, 5'd1,  5'd2, 5'd3,  26'h0,       32'h0,        1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            do_start(ADDR_W'(10'h100 + i));
            send(tbl[i].m, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, 1'b1);
            check($sformatf("tbl%0d_we", i), imem_we, tbl[i].legal);
            if (tbl[i].legal) begin
                check($sformatf("tbl%0d_wdata", i), imem_wdata, tbl[i].word);
                check($sformatf("tbl%0d_addr", i), imem_addr, 10'h100 + i);
            end
            check($sformatf("tbl%0d_err", i), err_illegal, !tbl[i].legal);
            tick();
            check($sformatf("tbl%0d_done", i), {done, busy}, 2'b10);
        end

        // First write latency
        do_start(10'h010);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0);
        check("lat_we", imem_we, 1);
        check("lat_addr", imem_addr, 10'h010);
        check("lat_wdata", imem_wdata, 32'h00221820);
        check("lat_wc", word_count, 1);
        send(4'd0, 5'd0, 5'd0, 5'd0, 26'h0, 1'b1);
        tick();

        // Back-to-back words on consecutive cycles
        do_start(10'h010);
        send(4'd6, 5'd29, 5'd8, 5'd0, 26'h4, 1'b0);
        send(4'd4, 5'd5, 5'd0, 5'd0, 26'h0, 1'b0);
        send(4'd11, 5'd4, 5'd6, 5'd0, 26'hFFFF, 1'b1);
        check("b2b_busy_last", busy, 1);
        tick();
        check("b2b_count", got.size(), 3);
        if (got.size() == 3) begin
            check("b2b_w0", got[0].d, 32'h8FA80004); check("b2b_a0", got[0].a, 10'h010);
            check("b2b_w1", got[1].d, 32'h00A00014); check("b2b_a1", got[1].a, 10'h011);
            check("b2b_w2", got[2].d, 32'h4086FFFF); check("b2b_a2", got[2].a, 10'h012);
            check("b2b_cyc", got[2].c - got[0].c, 2);
        end
        check("b2b_done_busy", {done, busy}, 2'b10);

        // Address wrap
        do_start(10'h3FF);
        send(4'd12, 5'd0, 5'd0, 5'd0, 26'h40, 1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1);
        tick();
        check("wrap_count", got.size(), 2);
        if (got.size() == 2) begin
            check("wrap_w0", got[0].d, 32'h7C000040); check("wrap_a0", got[0].a, 10'h3FF);
            check("wrap_a1", got[1].a, 10'h000);
        end

        // Illegal mnemonic between two ADDs
        do_start(10'h050);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0);
        send(4'd14, 5'd1, 5'd2, 5'd3, 26'h0, 1'b0);
        send(4'd0, 5'd4, 5'd5, 5'd6, 26'h0, 1'b1);
        tick();
        check("ill_count", got.size(), 2);
        if (got.size() == 2) begin
            check("ill_a0", got[0].a, 10'h050); check("ill_a1", got[1].a, 10'h051);
        end
        check("ill_err", err_illegal, 1);
        check("ill_wc", word_count, 2);
        check("ill_done", done, 1);

        // Overflow with in_valid held high for six cycles
        do_start(10'h000);
        in_mnem = 4'd0; in_rd = 5'd1; in_rt = 5'd0; in_imm = '0; in_last = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_rs = 5'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("ovf_count", got.size(), 4);
        check("ovf_ready", in_ready, 0);
        check("ovf_flags", {overflow, done}, 2'b10);
        check("ovf_wc", word_count, 4);

        // Randomised sessions against the reference model
        do_reset();
        for (int s = 0; s < 25; s++) begin
            base = $urandom_range(0, 1023);
            len  = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                rm[i]  = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(13, 15)) : 4'($urandom_range(0, 12));
                rrs[i] = 5'($urandom); rrt[i] = 5'($urandom); rrd[i] = 5'($urandom);
                rim[i] = 26'($urandom);
            end
            exp_q.delete();
            written = 0; n_acc = 0; closed = 0; m_done = 0; m_ovf = 0; m_err = 0;
            for (int i = 0; i < len; i++) begin
                if (!closed) begin
                    n_acc++;
                    if (rm[i] > 12) m_err = 1;
                    else begin
                        exp_q.push_back('{ADDR_W'((base + written) % 1024),
                                         ref_enc(int'(rm[i]), rrs[i], rrt[i], rrd[i], rim[i]), 0});
                        written++;
                    end
                    if (i == len - 1) begin m_done = 1; closed = 1; end
                    else if (rm[i] <= 12 && written == MAX_WORDS) begin m_ovf = 1; closed = 1; end
                end
            end
            do_start(ADDR_W'(base));
            for (int i = 0; i < n_acc; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                send(rm[i], rrs[i], rrt[i], rrd[i], rim[i], i == len - 1);
            end
            if (m_ovf) check($sformatf("rnd%0d_ready", s), in_ready, 0);
            tick(); tick();
            check($sformatf("rnd%0d_count", s), got.size(), exp_q.size());
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                check($sformatf("rnd%0d_a%0d", s, i), got[i].a, exp_q[i].a);
                check($sformatf("rnd%0d_w%0d", s, i), got[i].d, exp_q[i].d);
            end
            check($sformatf("rnd%0d_flags", s), {done, overflow, err_illegal, busy}, {m_done, m_ovf, m_err, 1'b0});
            check($sformatf("rnd%0d_wc", s), word_count, written);
        end

        // Reset in the cycle after a transfer drops the pending write
        do_start(10'h020);
        in_mnem = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rstmid_we", imem_we, 0);
        tick();
        reset = 1'b0;
        check("rstmid_count", got.size(), 0);
        check("rstmid_outs", {imem_we, busy, done, overflow, err_illegal, in_ready}, 0);
        check("rstmid_addr_data_wc", {imem_addr, imem_wdata, word_count}, 0);
        do_start(10'h100);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'h0, 1'b1);
        check("rstmid_new_addr", imem_addr, 10'h100);
        check("rstmid_new_wc", word_count, 1);
        check("rstmid_new_we", imem_we, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
